// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared definitions for the BlackParrot FPGA host NBF loader.
// Holds the AXI-Lite register offsets (decoded on addr[3:0]), the AXI
// response encodings and the write/read channel state types.
package blackparrot_fpga_host_pkg;

  // Register offsets within the 16-byte window
  localparam logic [3:0] REG_NBF_DATA  = 4'h0;
  localparam logic [3:0] REG_FIFO_FREE = 4'h4;
  localparam logic [3:0] REG_WORDS_IN  = 4'h8;
  localparam logic [3:0] REG_WORDS_OUT = 4'hC;

  // AXI response encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    e_w_idle,
    e_w_resp
  } w_state_e;

  typedef enum logic {
    e_r_idle,
    e_r_resp
  } r_state_e;

endpackage

// File: rtl/blackparrot_fpga_host_fifo_arst.sv
// Generic width_p x els_p FIFO with asynchronous active-low reset.
// The head word sits in an output register (data_o); the remaining words
// live in an array with a registered read into that head register.
// data_o holds its last value while the FIFO is empty.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   v_i/ready_o/data_i  input side; a push occurs when v_i & ready_o
//   v_o/yumi_i/data_o   output side; yumi_i pops the head (only when v_o)
//   count_o           current occupancy, 0..els_p
module blackparrot_fpga_host_fifo_arst
#(
  parameter int width_p = 32,
  parameter int els_p   = 16
)
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [width_p-1:0]         data_i,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  logic [width_p-1:0] mem [els_p];

  logic [ptr_w-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ptr_w-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [cnt_w-1:0]   count_reg, count_next;
  logic               valid_reg, valid_next;
  logic [width_p-1:0] data_reg, data_next;
  logic               mem_we;
  logic               push, pop, mem_empty;

  assign ready_o = (count_reg != cnt_w'(els_p));
  assign v_o     = valid_reg;
  assign data_o  = data_reg;
  assign count_o = count_reg;

  assign push = v_i & ready_o;
  assign pop  = yumi_i & valid_reg;
  // Array holds at most els_p-1 words (head is in data_reg), so equal
  // pointers can only mean the array is empty.
  assign mem_empty = (rd_ptr_reg == wr_ptr_reg);

  always_comb begin
    valid_next  = valid_reg;
    data_next   = data_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    mem_we      = 1'b0;
    count_next  = count_reg;

    if (!valid_reg) begin
      if (push) begin
        data_next  = data_i;
        valid_next = 1'b1;
      end
    end else if (pop) begin
      if (mem_empty) begin
        // Head leaves; an incoming word becomes the new head directly
        if (push) data_next = data_i;
        else      valid_next = 1'b0;
      end else begin
        data_next   = mem[rd_ptr_reg];
        rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push) begin
          mem_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
        end
      end
    end else if (push) begin
      mem_we      = 1'b1;
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + cnt_w'(1);
      2'b01:   count_next = count_reg - cnt_w'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
    end
  end

endmodule

// File: rtl/blackparrot_fpga_host_axil_nbf.sv
// AXI-Lite subordinate that accepts host MMIO writes of serialized NBF words,
// buffers them in a FIFO and streams them out over a valid/ready-and port.
// Read-only status: FIFO_FREE, WORDS_IN, WORDS_OUT.
// Ports:
//   s_axil_*        AXI-Lite subordinate (AW/W/B write, AR/R read)
//   nbf_v_o/nbf_data_o/nbf_ready_and_i  NBF word stream to the deserializer
module blackparrot_fpga_host_axil_nbf
  import blackparrot_fpga_host_pkg::*;
#(
  parameter int S_AXIL_ADDR_WIDTH = 32,
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int fifo_data_width_p = 32,
  parameter int fifo_els_p        = 16
)
(
  input  logic                           s_axil_aclk,
  input  logic                           s_axil_aresetn,
  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic                           nbf_v_o,
  output logic [fifo_data_width_p-1:0]   nbf_data_o,
  input  logic                           nbf_ready_and_i
);

  localparam int cnt_w = $clog2(fifo_els_p+1);

  logic       clk, rst_n;
  assign clk   = s_axil_aclk;
  assign rst_n = s_axil_aresetn;

  // Protection bits and undecoded address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  w_state_e   w_state_reg, w_state_next;
  r_state_e   r_state_reg, r_state_next;
  logic [1:0] bresp_reg, bresp_next;
  logic [1:0] rresp_reg, rresp_next;
  logic [S_AXIL_DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [31:0] words_in_reg, words_out_reg;

  logic [3:0]       wr_off, rd_off;
  logic             wr_is_data;
  logic             aw_hs, ar_hs, push, pop;
  logic             fifo_ready;
  logic [cnt_w-1:0] fifo_count;
  logic [31:0]      fifo_free;

  assign wr_off     = s_axil_awaddr[3:0];
  assign rd_off     = s_axil_araddr[3:0];
  assign wr_is_data = (wr_off == REG_NBF_DATA);

  // AW and W are taken together; a full FIFO only back-pressures data writes.
  // The rst_n term keeps the readies low while reset is held.
  assign aw_hs = rst_n && (w_state_reg == e_w_idle) && s_axil_awvalid && s_axil_wvalid
                 && !(wr_is_data && !fifo_ready);
  assign s_axil_awready = aw_hs;
  assign s_axil_wready  = aw_hs;

  assign push = aw_hs && wr_is_data && (s_axil_wstrb == 4'hF);
  assign pop  = nbf_v_o && nbf_ready_and_i;

  assign s_axil_bvalid = (w_state_reg == e_w_resp);
  assign s_axil_bresp  = bresp_reg;

  assign s_axil_arready = rst_n && (r_state_reg == e_r_idle);
  assign ar_hs          = s_axil_arready && s_axil_arvalid;
  assign s_axil_rvalid  = (r_state_reg == e_r_resp);
  assign s_axil_rdata   = rdata_reg;
  assign s_axil_rresp   = rresp_reg;

  assign fifo_free = 32'(fifo_els_p) - 32'(fifo_count);

  // Write channel
  always_comb begin
    w_state_next = w_state_reg;
    bresp_next   = bresp_reg;
    case (w_state_reg)
      e_w_idle: begin
        if (aw_hs) begin
          w_state_next = e_w_resp;
          bresp_next   = push ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
      end
      e_w_resp: begin
        if (s_axil_bready) w_state_next = e_w_idle;
      end
      default: w_state_next = e_w_idle;
    endcase
  end

  // Read channel; status is sampled in the AR handshake cycle
  always_comb begin
    r_state_next = r_state_reg;
    rdata_next   = rdata_reg;
    rresp_next   = rresp_reg;
    case (r_state_reg)
      e_r_idle: begin
        if (ar_hs) begin
          r_state_next = e_r_resp;
          rresp_next   = AXI_RESP_OKAY;
          case (rd_off)
            REG_NBF_DATA:  rdata_next = '0;
            REG_FIFO_FREE: rdata_next = fifo_free;
            REG_WORDS_IN:  rdata_next = words_in_reg;
            REG_WORDS_OUT: rdata_next = words_out_reg;
            default: begin
              rdata_next = '0;
              rresp_next = AXI_RESP_SLVERR;
            end
          endcase
        end
      end
      e_r_resp: begin
        if (s_axil_rready) r_state_next = e_r_idle;
      end
      default: r_state_next = e_r_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg   <= e_w_idle;
      r_state_reg   <= e_r_idle;
      bresp_reg     <= AXI_RESP_OKAY;
      rresp_reg     <= AXI_RESP_OKAY;
      rdata_reg     <= '0;
      words_in_reg  <= '0;
      words_out_reg <= '0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      bresp_reg   <= bresp_next;
      rresp_reg   <= rresp_next;
      rdata_reg   <= rdata_next;
      if (push) words_in_reg  <= words_in_reg + 32'd1;
      if (pop)  words_out_reg <= words_out_reg + 32'd1;
    end
  end

  blackparrot_fpga_host_fifo_arst #(
    .width_p (fifo_data_width_p),
    .els_p   (fifo_els_p)
  ) nbf_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .v_i     (push),
    .ready_o (fifo_ready),
    .data_i  (s_axil_wdata),
    .v_o     (nbf_v_o),
    .yumi_i  (pop),
    .data_o  (nbf_data_o),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_nbf.sv
module tb_blackparrot_fpga_host_axil_nbf;

  localparam int ELS = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        nbf_v;
  logic [31:0] nbf_data;
  logic        nbf_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int wi = 0;
  int wo = 0;

  logic [31:0] nbf_q[$];
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];

  always #5 clk = ~clk;

  blackparrot_fpga_host_axil_nbf dut (
    .s_axil_aclk     (clk),
    .s_axil_aresetn  (rst_n),
    .s_axil_awaddr   (awaddr),
    .s_axil_awprot   (awprot),
    .s_axil_awvalid  (awvalid),
    .s_axil_awready  (awready),
    .s_axil_wdata    (wdata),
    .s_axil_wstrb    (wstrb),
    .s_axil_wvalid   (wvalid),
    .s_axil_wready   (wready),
    .s_axil_bresp    (bresp),
    .s_axil_bvalid   (bvalid),
    .s_axil_bready   (bready),
    .s_axil_araddr   (araddr),
    .s_axil_arprot   (arprot),
    .s_axil_arvalid  (arvalid),
    .s_axil_arready  (arready),
    .s_axil_rdata    (rdata),
    .s_axil_rresp    (rresp),
    .s_axil_rvalid   (rvalid),
    .s_axil_rready   (rready),
    .nbf_v_o         (nbf_v),
    .nbf_data_o      (nbf_data),
    .nbf_ready_and_i (nbf_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Stream-side scoreboard: every handshake pops the oldest expected word
  always @(negedge clk) begin
    if (rst_n && nbf_v && nbf_ready) begin
      check("nbf_expected_pending", 32'(nbf_q.size() != 0), 32'd1);
      if (nbf_q.size() != 0) begin
        logic [31:0] e;
        e = nbf_q.pop_front();
        check("nbf_data", nbf_data, e);
        $display("NBF  out data=%h", nbf_data);
      end
      wo++;
    end
  end

  task automatic wait_b(input string tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bvalid) break;
    end
    if (n == 200) check({tag, "_b_timeout"}, 32'd0, 32'd1);
    else begin
      logic [1:0] e;
      e = b_q.pop_front();
      check({tag, "_bresp"}, 32'(bresp), 32'(e));
      $display("WR   %s addr=%h data=%h strb=%h bresp=%0d", tag, awaddr[3:0], wdata, wstrb, bresp);
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit first);
    int n;
    bit ok;
    ok = (addr == 4'h0) && (strb == 4'hF);
    b_q.push_back(ok ? OKAY : SLVERR);
    if (ok) begin
      nbf_q.push_back(data);
      wi++;
    end
    awaddr  = {28'($urandom()), addr};
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (first) check("nbf_v_before_push", 32'(nbf_v), 32'd0);
      if (awready) break;
    end
    if (n == 200) check({tag, "_aw_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (first) begin
      check("nbf_v_rise", 32'(nbf_v), 32'd1);
      check("nbf_first_data", nbf_data, data);
    end
    wait_b(tag);
  endtask

  task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int n;
    logic [33:0] e;
    r_q.push_back({exp_resp, exp_data});
    araddr  = {28'($urandom()), addr};
    arvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (n == 200) check({tag, "_ar_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    if (n == 200) check({tag, "_r_timeout"}, 32'd0, 32'd1);
    else begin
      e = r_q.pop_front();
      check({tag, "_rdata"}, rdata, e[31:0]);
      check({tag, "_rresp"}, 32'(rresp), 32'(e[33:32]));
      $display("RD   %s addr=%h rdata=%h rresp=%0d", tag, addr, rdata, rresp);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (nbf_q.size() == 0) break;
    end
    if (n == 200) check({tag, "_drain_timeout"}, 32'(nbf_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] re;
    logic [1:0]  be;

    // Reset: outputs quiet even with requests pending
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_nbf_v", 32'(nbf_v), 32'd0);
    check("rst_nbf_data", nbf_data, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", 32'({bresp, rresp}), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    axi_read("free0", 4'h4, 32'd16, OKAY);
    axi_read("win0", 4'h8, 32'd0, OKAY);
    axi_read("wout0", 4'hC, 32'd0, OKAY);
    axi_read("data_rd", 4'h0, 32'd0, OKAY);

    // Streaming with downstream ready
    axi_write("w_dead", 4'h0, 32'hDEADBEEF, 4'hF, 1'b1);
    axi_write("w_three", 4'h0, 32'h00000003, 4'hF, 1'b0);
    axi_write("w_msb", 4'h0, 32'h80000000, 4'hF, 1'b0);
    drain("stream");
    axi_read("win3", 4'h8, 32'(wi), OKAY);
    axi_read("wout3", 4'hC, 32'(wo), OKAY);
    check("wout_model", 32'(wo), 32'd3);

    // Fill the FIFO with the stream stalled
    nbf_ready = 1'b0;
    for (int i = 0; i < ELS; i++) axi_write("fill", 4'h0, 32'h1000 + 32'(i), 4'hF, 1'b0);
    axi_read("free_full", 4'h4, 32'd0, OKAY);
    b_q.push_back(OKAY);
    nbf_q.push_back(32'h00002000);
    wi++;
    awaddr = 32'h0; wdata = 32'h00002000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_stall", 32'(awready), 32'd0);
    end
    @(posedge clk); #1;
    nbf_ready = 1'b1;
    @(negedge clk);
    check("full_no_bypass", 32'(awready), 32'd0);
    @(posedge clk); #1;
    nbf_ready = 1'b0;
    @(negedge clk);
    check("unstall_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b("w17");
    nbf_ready = 1'b1;
    drain("full");
    axi_read("win20", 4'h8, 32'(wi), OKAY);
    axi_read("wout20", 4'hC, 32'(wo), OKAY);
    axi_read("free_empty", 4'h4, 32'd16, OKAY);

    // Error paths
    axi_write("w_strb", 4'h0, 32'h55555555, 4'h3, 1'b0);
    @(negedge clk);
    check("strb_no_push", 32'(nbf_v), 32'd0);
    axi_read("win_strb", 4'h8, 32'(wi), OKAY);
    axi_write("w_free", 4'h4, 32'h12345678, 4'hF, 1'b0);
    axi_write("w_mis", 4'h2, 32'h12345678, 4'hF, 1'b0);
    axi_read("rd_mis", 4'h6, 32'd0, SLVERR);

    // Concurrent read and write with both responses back-pressured
    bready = 1'b0; rready = 1'b0;
    b_q.push_back(OKAY);
    nbf_q.push_back(32'hCAFE0001);
    r_q.push_back({OKAY, 32'(wi)});
    wi++;
    awaddr = 32'h0; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h8; arvalid = 1'b1;
    @(negedge clk);
    check("cc_awready", 32'(awready), 32'd1);
    check("cc_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    wdata = 32'hCAFE0002; araddr = 32'h4;
    re = r_q[0];
    be = b_q[0];
    repeat (5) begin
      @(negedge clk);
      check("hold_bvalid", 32'(bvalid), 32'd1);
      check("hold_bresp", 32'(bresp), 32'(be));
      check("hold_rvalid", 32'(rvalid), 32'd1);
      check("hold_rdata", rdata, re[31:0]);
      check("hold_rresp", 32'(rresp), 32'(re[33:32]));
      check("hold_no_aw", 32'(awready), 32'd0);
      check("hold_no_ar", 32'(arready), 32'd0);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    be = b_q.pop_front();
    re = r_q.pop_front();
    check("cc_bresp", 32'(bresp), 32'(be));
    check("cc_rdata", rdata, re[31:0]);
    $display("WR   cc addr=0 data=cafe0001 bresp=%0d / RD cc addr=8 rdata=%h", bresp, rdata);
    @(posedge clk); #1;
    @(negedge clk);
    check("cc_b_done", 32'(bvalid), 32'd0);
    check("cc_r_done", 32'(rvalid), 32'd0);
    drain("cc");

    // Asynchronous reset with words buffered
    nbf_ready = 1'b0;
    for (int i = 0; i < 5; i++) axi_write("pre_rst", 4'h0, 32'hA0 + 32'(i), 4'hF, 1'b0);
    @(negedge clk);
    check("pre_rst_nbf_v", 32'(nbf_v), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_nbf_v", 32'(nbf_v), 32'd0);
    check("arst_nbf_data", nbf_data, 32'd0);
    check("arst_awready", 32'(awready), 32'd0);
    check("arst_arready", 32'(arready), 32'd0);
    nbf_q.delete(); b_q.delete(); r_q.delete();
    wi = 0; wo = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nbf_ready = 1'b1;
    axi_read("free_post", 4'h4, 32'd16, OKAY);
    axi_read("win_post", 4'h8, 32'd0, OKAY);
    axi_read("wout_post", 4'hC, 32'd0, OKAY);
    check("post_nbf_v", 32'(nbf_v), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
